// File: rtl/bnn_param_loader_pkg.sv
// Shared types and sizing helpers for the BNN parameter loader.
package bnn_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BYTE,
        SHIFT,
        DONE
    } loader_state_t;

    localparam int NEURON_INPUTS    = 8;
    localparam int NEURON_BIAS_BITS = 3;
    localparam int BYTE_W           = 8;

    // Bits held by a daisy chain of `neurons` neurons (weights plus bias).
    function automatic int chain_bits(input int neurons);
        return neurons * (NEURON_INPUTS + NEURON_BIAS_BITS);
    endfunction

endpackage

// File: rtl/bnn_param_loader_if.sv
// Byte source / serial chain bundle between the parameter source and the loader.
interface bnn_param_loader_if #(
    parameter int CNT_W = 5
);
    logic             start;
    logic [7:0]       data_in;
    logic             data_valid;
    logic             data_ready;
    logic             setup;
    logic             param_out;
    logic             busy;
    logic             loaded;
    logic [CNT_W-1:0] bits_loaded;

    modport master (
        output start, data_in, data_valid,
        input  data_ready, setup, param_out, busy, loaded, bits_loaded
    );

    modport slave (
        input  start, data_in, data_valid,
        output data_ready, setup, param_out, busy, loaded, bits_loaded
    );
endinterface

// File: rtl/bnn_param_loader_byte_serializer.sv
// 8-bit MSB-first shift register; last_bit_o flags the final bit of the current byte.
module byte_serializer
    import bnn_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic              shift_i,
    input  logic              truncate_i,
    input  logic [BYTE_W-1:0] data_i,
    output logic              msb_o,
    output logic              last_bit_o
);
    logic [BYTE_W-1:0] sr_q;
    logic [2:0]        idx_q;

    // Load beats shift so a byte can be taken on the previous byte's last bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q  <= '0;
            idx_q <= '0;
        end else if (clear_i) begin
            sr_q  <= '0;
            idx_q <= '0;
        end else if (load_i) begin
            sr_q  <= data_i;
            idx_q <= 3'd7;
        end else if (shift_i) begin
            sr_q  <= {sr_q[BYTE_W-2:0], 1'b0};
            idx_q <= idx_q - 3'd1;
        end
    end

    assign msb_o      = sr_q[BYTE_W-1];
    assign last_bit_o = (idx_q == 3'd0) | truncate_i;

endmodule

// File: rtl/bnn_param_loader.sv
// Serialises parameter bytes onto the neuron daisy chain and stops after CHAIN_BITS bits.
module bnn_param_loader
    import bnn_pkg::*;
#(
    parameter int CHAIN_BITS = chain_bits(2),
    parameter int CNT_W      = $clog2(CHAIN_BITS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    bnn_param_loader_if.slave ld_if
);
    loader_state_t    state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             setup_q;
    logic             param_q;
    logic             loaded_q;

    logic sh_msb;
    logic sh_last;
    logic final_bit;
    logic in_shift;
    logic byte_end;
    logic accept;

    assign in_shift  = (state_q == SHIFT);
    assign final_bit = (cnt_q == CNT_W'(CHAIN_BITS - 1));
    assign byte_end  = in_shift & sh_last;

    // Ready on the last bit of a byte keeps the stream bubble-free, except when
    // that bit completes the chain.
    assign ld_if.data_ready = ((state_q == WAIT_BYTE) | (byte_end & ~final_bit)) & ~ld_if.start;
    assign accept           = ld_if.data_valid & ld_if.data_ready;

    byte_serializer u_ser (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (ld_if.start),
        .load_i     (accept),
        .shift_i    (in_shift & ~ld_if.start),
        .truncate_i (final_bit),
        .data_i     (ld_if.data_in),
        .msb_o      (sh_msb),
        .last_bit_o (sh_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            setup_q  <= 1'b0;
            param_q  <= 1'b0;
            loaded_q <= 1'b0;
        end else if (ld_if.start) begin
            state_q  <= WAIT_BYTE;
            cnt_q    <= '0;
            setup_q  <= 1'b0;
            loaded_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    setup_q <= 1'b0;
                end
                WAIT_BYTE: begin
                    setup_q <= 1'b0;
                    if (accept) state_q <= SHIFT;
                end
                SHIFT: begin
                    setup_q <= 1'b1;
                    param_q <= sh_msb;
                    if (cnt_q != CNT_W'(CHAIN_BITS)) cnt_q <= cnt_q + CNT_W'(1);
                    if (final_bit)             state_q <= DONE;
                    else if (sh_last & ~accept) state_q <= WAIT_BYTE;
                end
                DONE: begin
                    setup_q  <= 1'b0;
                    loaded_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    setup_q <= 1'b0;
                end
            endcase
        end
    end

    assign ld_if.setup       = setup_q;
    assign ld_if.param_out   = param_q;
    assign ld_if.loaded      = loaded_q;
    assign ld_if.busy        = (state_q == WAIT_BYTE) | in_shift;
    assign ld_if.bits_loaded = cnt_q;

endmodule

// File: tb/tb_bnn_param_loader.sv
// Bench for bnn_param_loader: table-driven load scenarios with a bit scoreboard plus corner sequences.
module tb_bnn_param_loader;
    import bnn_pkg::*;

    localparam int CB = 22;
    localparam int CW = $clog2(CB + 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bnn_param_loader_if #(.CNT_W(CW)) lif ();

    bnn_param_loader #(.CHAIN_BITS(CB), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ld_if (lif)
    );

    typedef struct {
        logic [0:3][7:0] bytes;  // three payload bytes plus one that must never be taken
        int              gap;    // idle cycles the source waits after each accept
        int              lat;    // edges from first accept to loaded visible
        int              gaps;   // setup=0 cycles inside the bit stream
    } sc_t;

    sc_t  tbl[4];
    logic exp_q[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   pushed = 0;
    int   setups = 0;
    bit   acc;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // One clock: capture handshake before the edge, score the serial output after it.
    task automatic cycle();
        logic st;
        logic b;
        #1;
        st  = lif.start;
        acc = lif.data_valid && lif.data_ready;
        if (acc) begin
            for (int k = 7; k >= 0; k--) begin
                if (pushed < CB) begin
                    exp_q.push_back(lif.data_in[k]);
                    pushed++;
                end
            end
        end
        @(posedge clk);
        #1;
        if (st) begin
            exp_q.delete();
            pushed = 0;
            setups = 0;
        end
        if (lif.setup) begin
            if (exp_q.size() == 0) begin
                check("setup_unexpected", int'(lif.setup), 0);
            end else begin
                setups++;
                b = exp_q.pop_front();
                check("param_out", int'(lif.param_out), int'(b));
            end
        end
        check("bits_loaded", int'(lif.bits_loaded), setups);
    endtask

    task automatic run_load(input sc_t s, input bit do_start);
        int bi, gapc, first_acc, loaded_at, first_set, gapcyc, accs;
        lif.data_valid = 1'b0;
        if (do_start) begin
            lif.start = 1'b1;
            cycle();
            lif.start = 1'b0;
        end
        bi = 0; gapc = 0; first_acc = -1; loaded_at = -1; first_set = -1; gapcyc = 0; accs = 0;
        for (int c = 0; c < 300 && loaded_at < 0; c++) begin
            if (gapc > 0) begin
                lif.data_valid = 1'b0;
                gapc--;
            end else begin
                lif.data_valid = 1'b1;
                lif.data_in    = s.bytes[bi];
            end
            cycle();
            if (acc) begin
                if (first_acc < 0) first_acc = c;
                accs++;
                if (bi < 3) bi++;
                gapc = s.gap;
            end
            if (lif.setup) begin
                if (first_set < 0) first_set = c;
            end else if (first_set >= 0 && !lif.loaded) begin
                gapcyc++;
            end
            if (lif.loaded) loaded_at = c;
        end
        check("load_latency", loaded_at - first_acc, s.lat);
        check("setup_cycles", setups, CB);
        check("gap_cycles", gapcyc, s.gaps);
        check("accepts", accs, 3);
        check("sb_empty", exp_q.size(), 0);
        check("busy_done", int'(lif.busy), 0);
        #1;
        check("ready_done", int'(lif.data_ready), 0);
        lif.data_valid = 1'b0;
    endtask

    initial begin
        int bi;
        lif.start      = 1'b0;
        lif.data_valid = 1'b0;
        lif.data_in    = 8'h00;

        tbl[0] = '{bytes: {8'hA5, 8'h3C, 8'hF0, 8'hFF}, gap: 0,  lat: 23, gaps: 0};
        tbl[1] = '{bytes: {8'hA5, 8'h3C, 8'hF0, 8'hFF}, gap: 10, lat: 29, gaps: 6};
        tbl[2] = '{bytes: {8'h5A, 8'hC3, 8'h0F, 8'hFF}, gap: 8,  lat: 25, gaps: 2};
        tbl[3] = '{bytes: {8'hFF, 8'h00, 8'h81, 8'hAA}, gap: 3,  lat: 23, gaps: 0};

        // Reset, then idle with a byte offered but no start
        repeat (3) @(posedge clk);
        #1;
        check("rst_setup", int'(lif.setup), 0);
        check("rst_param", int'(lif.param_out), 0);
        check("rst_ready", int'(lif.data_ready), 0);
        check("rst_busy", int'(lif.busy), 0);
        check("rst_loaded", int'(lif.loaded), 0);
        check("rst_bits", int'(lif.bits_loaded), 0);
        rst_n          = 1'b1;
        lif.data_valid = 1'b1;
        lif.data_in    = 8'hFF;
        cycle();
        check("idle_no_accept", int'(acc), 0);
        cycle();
        check("idle_setup", int'(lif.setup), 0);
        check("idle_busy", int'(lif.busy), 0);
        lif.data_valid = 1'b0;

        for (int i = 0; i < 4; i++) run_load(tbl[i], 1'b1);

        // Post-done: further bytes are ignored
        for (int i = 0; i < 5; i++) begin
            lif.data_valid = 1'b1;
            lif.data_in    = 8'($urandom);
            #1;
            check("done_ready", int'(lif.data_ready), 0);
            repeat (8) cycle();
            check("done_loaded", int'(lif.loaded), 1);
            check("done_bits", int'(lif.bits_loaded), CB);
        end
        lif.data_valid = 1'b0;

        // Restart after 10 bits, coincident with a valid byte
        lif.start = 1'b1;
        cycle();
        lif.start = 1'b0;
        bi = 0;
        for (int c = 0; c < 60 && setups < 10; c++) begin
            lif.data_valid = 1'b1;
            lif.data_in    = tbl[0].bytes[bi];
            cycle();
            if (acc) bi++;
        end
        check("restart_reach10", setups, 10);
        lif.start      = 1'b1;
        lif.data_valid = 1'b1;
        lif.data_in    = 8'h77;
        #1;
        check("restart_ready", int'(lif.data_ready), 0);
        cycle();
        check("restart_no_accept", int'(acc), 0);
        lif.start      = 1'b0;
        lif.data_valid = 1'b0;
        check("restart_setup", int'(lif.setup), 0);
        check("restart_bits", int'(lif.bits_loaded), 0);
        check("restart_busy", int'(lif.busy), 1);
        check("restart_loaded", int'(lif.loaded), 0);
        cycle();
        check("restart_setup2", int'(lif.setup), 0);
        run_load(tbl[0], 1'b0);

        // Asynchronous reset in the middle of a byte
        lif.start = 1'b1;
        cycle();
        lif.start      = 1'b0;
        lif.data_valid = 1'b1;
        lif.data_in    = 8'hFF;
        cycle();
        lif.data_valid = 1'b0;
        cycle();
        cycle();
        check("pre_rst_setup", int'(lif.setup), 1);
        check("pre_rst_param", int'(lif.param_out), 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_setup", int'(lif.setup), 0);
        check("arst_busy", int'(lif.busy), 0);
        check("arst_param", int'(lif.param_out), 0);
        check("arst_bits", int'(lif.bits_loaded), 0);
        check("arst_ready", int'(lif.data_ready), 0);
        exp_q.delete();
        pushed = 0;
        setups = 0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_setup", int'(lif.setup), 0);
        check("post_rst_busy", int'(lif.busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bnn_param_loader.md
# bnn_param_loader

Upstream configuration stage for the neuron daisy chain. Accepts weight/bias bytes over a valid/ready handshake and shifts them out one bit per cycle on `param_out`. While a bit is presented it drives `setup`, so every neuron in the chain shifts in lockstep. It counts the total bits delivered and stops at exactly `CHAIN_BITS`, then reports `loaded` so the inference path can be enabled.

## Interface
Parameters:
- `CHAIN_BITS`, default 22: total bits in the chain (2 neurons × (8 weights + 3 bias)); must be ≥ 1.
- `CNT_W`, default `$clog2(CHAIN_BITS+1)`: width of the bit counter.

Ports:
- `clk` input 1: single clock, all state on rising edge.
- `rst_n` input 1: reset, asynchronous assert, active-low.
- `start` input 1: one-cycle pulse; begins a new load and discards any load in progress.
- `data_in` input 8: parameter byte, MSB shifted first.
- `data_valid` input 1: `data_in` is valid.
- `data_ready` output 1: loader accepts a byte this cycle (combinational from state).
- `setup` output 1: chain shift enable; registered.
- `param_out` output 1: serial bit to the first neuron's `param_in`; registered, aligned with `setup`.
- `busy` output 1: a load is in progress.
- `loaded` output 1: all `CHAIN_BITS` delivered; held until the next `start`.
- `bits_loaded` output `CNT_W`: number of bits shifted so far.

## Operation
- States:
  - IDLE: reset state.
  - WAIT_BYTE: `data_ready`=1.
  - SHIFT: serialising a byte.
  - DONE.
- IDLE→WAIT_BYTE on `start`. In any other state, `start` returns the block to WAIT_BYTE and clears the counter, the shift register and `loaded`. `setup` drops the next cycle.
- Byte accept: `data_valid & data_ready` loads the 8-bit shift register and sets the bit index to 7. The state goes to SHIFT.
- SHIFT: each cycle drives `param_out`=current MSB and `setup`=1, then shifts left and increments `bits_loaded`.
- A byte ends after 8 bits, or earlier when `bits_loaded` reaches `CHAIN_BITS`. Unused low bits of the final byte are discarded.
- Back-to-back bytes: `data_ready` is also 1 on the last bit cycle of a byte, unless that bit completes the chain. A byte accepted then starts shifting on the very next cycle, giving 8 cycles/byte with no bubble.
- When `bits_loaded` reaches `CHAIN_BITS`, the state goes to DONE:
  - `loaded`=1, `busy`=0, `data_ready`=0.
  - Further `data_valid` is ignored and `setup` stays 0.
- `busy`=1 in WAIT_BYTE and SHIFT.
- `data_ready` = (WAIT_BYTE, or last non-final bit cycle of SHIFT) & ~`start`. When `start` and `data_valid` coincide, `start` wins and no byte is accepted.
- `setup` is never 1 outside SHIFT, so neurons never shift spuriously.

## Timing
- Reset values: `setup`=0, `param_out`=0, `data_ready`=0, `busy`=0, `loaded`=0, `bits_loaded`=0, state IDLE.
- Byte accepted at edge N → `setup`=1 with bit 7 visible after edge N+1. Bit k is visible after edge N+8−k.
- Load latency from the first accepted byte: `CHAIN_BITS`+1 cycles to `loaded`=1, provided the source never stalls.
- Stalls (`data_valid`=0 in WAIT_BYTE): `setup`=0 and `param_out` holds its value. No bit is counted.
- `bits_loaded` saturates at `CHAIN_BITS` and never wraps.
- Reset asserted mid-shift: all outputs return to reset values immediately (asynchronous). The chain contents are then undefined and a fresh `start` is required.

## Structure
- Package `bnn_pkg` holds:
  - the state enum `loader_state_t` (IDLE, WAIT_BYTE, SHIFT, DONE);
  - the localparams `NEURON_INPUTS`=8, `NEURON_BIAS_BITS`=3;
  - a function `chain_bits(neurons)` for the default `CHAIN_BITS`.
- One natural sub-module, `byte_serializer`. It loads 8 bits, shifts MSB-first, exposes `last_bit`, and takes a truncate input driven from the counter compare. The FSM, counter and handshake stay in the top.

## Test plan
- **Reset then idle:** hold `rst_n`=0, then release with no `start` → all outputs 0; `data_valid`=1 with 0xFF is not accepted.
- **Full load, CHAIN_BITS=22:**
  - Stimulus: `start`, then bytes 0xA5, 0x3C, 0xF0 with `data_valid` held high.
  - `param_out` sequence: 10100101 00111100 111100; 22 `setup` cycles, contiguous.
  - `loaded`=1 on cycle 23 after the first accept; `data_ready`=0 on the third byte's last bit.
- **Stalled source:** same bytes with 3 idle cycles between them → identical bit stream, `setup`=0 during gaps, `bits_loaded` frozen.
- **Restart mid-load:**
  - Stimulus: `start` after 10 bits shifted, coincident with `data_valid`.
  - Required: no byte accepted, `bits_loaded`=0, `setup`=0 next cycle.
  - Reloading 3 bytes again yields `loaded` after 22 bits.
- **Post-done:** after `loaded`, drive 5 more bytes → `data_ready`=0, `setup` never asserts, `bits_loaded` stays 22.
- **Async reset during SHIFT:** drop `rst_n` between edges → `setup`, `busy`, `param_out` go 0 before the next edge.
